// File: rtl/sipo_frame_ctrl_pkg.sv
// sipo_frame_ctrl_pkg: FSM state encoding shared by the shift-register controllers
package sipo_frame_ctrl_pkg;
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;
endpackage

// File: rtl/sipo_frame_ctrl_if.sv
// sipo_frame_ctrl_if: serial input, parallel output handshake and status bundle
// master drives s_in/s_valid/s_start/p_ready; slave drives p_out/p_valid/busy/bit_cnt/frame_err/overrun
interface sipo_frame_ctrl_if #(parameter int WIDTH = 4);
  localparam int CNT_W = $clog2(WIDTH + 1);
  logic s_in;
  logic s_valid;
  logic s_start;
  logic [WIDTH-1:0] p_out;
  logic p_valid;
  logic p_ready;
  logic busy;
  logic [CNT_W-1:0] bit_cnt;
  logic frame_err;
  logic overrun;
  modport master (
    output s_in, s_valid, s_start, p_ready,
    input  p_out, p_valid, busy, bit_cnt, frame_err, overrun
  );
  modport slave (
    input  s_in, s_valid, s_start, p_ready,
    output p_out, p_valid, busy, bit_cnt, frame_err, overrun
  );
endinterface

// File: rtl/sipo_shift_reg.sv
// sipo_shift_reg: MSB-first shift register; ports clk, clear (sync reset), shift_en, s_in, q
module sipo_shift_reg #(parameter int WIDTH = 4) (
  input  logic             clk,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             s_in,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk)
    if (clear) q <= '0;
    else if (shift_en) q <= {q[WIDTH-2:0], s_in};
endmodule

// File: rtl/sipo_frame_ctrl.sv
// sipo_frame_ctrl: frames a serial bit stream into WIDTH-bit words with a one-deep valid/ready output buffer
// ports: clk, clear (sync reset), bus (slave side of sipo_frame_ctrl_if)
module sipo_frame_ctrl
  import sipo_frame_ctrl_pkg::*;
#(parameter int WIDTH = 4) (
  input logic clk,
  input logic clear,
  sipo_frame_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  state_t state;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] word;
  logic [CNT_W-1:0] cnt_nxt;
  logic accept;
  logic complete;
  // A restart needs no shifter flush: stale bits are shifted out before the word completes.
  always_comb begin
    accept = bus.s_valid && (state == ST_SHIFT || bus.s_start);
    cnt_nxt = bus.s_start ? CNT_W'(1) : bus.bit_cnt + CNT_W'(1);
    complete = accept && cnt_nxt == CNT_W'(WIDTH);
    word = {q[WIDTH-2:0], bus.s_in};
  end
  sipo_shift_reg #(.WIDTH(WIDTH)) u_shift (
    .clk(clk),
    .clear(clear),
    .shift_en(accept),
    .s_in(bus.s_in),
    .q(q)
  );
  assign bus.busy = state == ST_SHIFT;
  always_ff @(posedge clk)
    if (clear) begin
      state <= ST_IDLE;
      bus.bit_cnt <= '0;
      bus.p_out <= '0;
      bus.p_valid <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.overrun <= 1'b0;
    end else begin
      bus.frame_err <= bus.s_valid && bus.s_start && state == ST_SHIFT;
      bus.overrun <= complete && bus.p_valid && !bus.p_ready;
      if (accept) begin
        state <= complete ? ST_IDLE : ST_SHIFT;
        bus.bit_cnt <= complete ? '0 : cnt_nxt;
      end
      if (complete && (!bus.p_valid || bus.p_ready)) begin
        bus.p_out <= word;
        bus.p_valid <= 1'b1;
      end else if (bus.p_valid && bus.p_ready) bus.p_valid <= 1'b0;
    end
endmodule
